// File: rtl/data_ram_pipe_pkg.sv
// data_ram_pipe_pkg: shared FSM encoding and default constants for the data RAM
package data_ram_pipe_pkg;
    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam int DEF_DEPTH = 2048;
    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
    localparam bit CLR_EN = 1'b1;
    localparam bit CLR_DIS = 1'b0;
endpackage

// File: rtl/dram_rsp_pipe.sv
// dram_rsp_pipe: LAT-stage valid/err/data response shift register
module dram_rsp_pipe #(
    parameter int DATA_W = 32,
    parameter int LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              in_err,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_err,
    output logic [DATA_W-1:0] out_data
);
    logic [LAT-1:0] v, e;
    logic [DATA_W-1:0] d [LAT];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v <= '0;
            e <= '0;
            for (int i = 0; i < LAT; i++) d[i] <= '0;
        end else begin
            v[0] <= in_valid;
            e[0] <= in_err;
            d[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                e[i] <= e[i-1];
                d[i] <= d[i-1];
            end
        end
    assign out_valid = v[LAT-1];
    assign out_err = e[LAT-1];
    assign out_data = d[LAT-1];
endmodule

// File: rtl/data_ram_pipe.sv
// data_ram_pipe: CPU data RAM with req/rsp handshake, range check, pipelined read and post-reset clear
module data_ram_pipe import data_ram_pipe_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int DEPTH = DEF_DEPTH,
    parameter int ADDR_W = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(DEF_BASE_ADDR),
    parameter int RD_LAT = 2,
    parameter bit INIT_CLEAR = CLR_EN
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done,
    output logic [DATA_W-1:0]   dbg_word0
);
    localparam int NB = DATA_W / 8;
    localparam int LW = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam longint BYTES = longint'(DEPTH) * NB;

    state_t state, state_nx;
    logic [IW-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] off;
    logic [IW-1:0] idx;
    logic acc, err, clr, wr;
    logic [DATA_W-1:0] rd_data;

    always_comb begin
        off = req_addr - BASE_ADDR;
        err = 64'(off) >= 64'(BYTES);
        idx = off[IW+LW-1:LW];
        req_ready = state == ST_RUN;
        init_done = state == ST_RUN;
        acc = req_valid && req_ready;
        clr = state == ST_INIT && INIT_CLEAR;
        wr = acc && req_we && !err;
        rd_data = (acc && !req_we && !err) ? mem[idx] : '0;
        state_nx = (state == ST_RUN || !INIT_CLEAR || cnt == IW'(DEPTH - 1)) ? ST_RUN : ST_INIT;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ST_INIT;
            cnt <= '0;
        end else begin
            state <= state_nx;
            cnt <= clr ? cnt + 1'b1 : cnt;
        end

    // array has no reset; contents are defined only by the clear sequencer
    always_ff @(posedge clk)
        if (clr)
            mem[cnt] <= '0;
        else if (wr)
            for (int i = 0; i < NB; i++)
                if (req_sel[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];

    assign dbg_word0 = mem[0];

    dram_rsp_pipe #(.DATA_W(DATA_W), .LAT(RD_LAT)) u_rsp (
        .clk(clk),
        .rst_n(rst_n),
        .in_valid(acc),
        .in_err(acc && err),
        .in_data(rd_data),
        .out_valid(rsp_valid),
        .out_err(rsp_err),
        .out_data(rsp_rdata)
    );
endmodule

// File: doc/data_ram_pipe.md
Name: data_ram_pipe

Overview:
Parametrised successor of the single-cycle data RAM. It is the CPU data memory, with generic width, depth and base address, a req/rsp handshake, a configurable registered read latency, and an out-of-range error response. A hardware clear sequencer zeroes the array after reset. It sits behind the MEM stage and drives the load-data path; the debug word port feeds the board display logic.

Parameters:
DATA_W, 32, data word width in bits; multiple of 8, at least 8.
DEPTH, 2048, number of words; power of two.
ADDR_W, 32, request address width.
BASE_ADDR, 32'h1001_0000, byte address mapped to word 0.
RD_LAT, 2, cycles from request accept to rsp_valid; legal range 1..4.
INIT_CLEAR, 1, 1 = zero the whole array after reset, 0 = skip the clear.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  reset, asynchronous assert, active-low.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = write, 0 = read.
req_addr  in  ADDR_W  byte address.
req_sel  in  DATA_W/8  byte-lane enables; bit i covers data[8i+7:8i].
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-cycle pulse per accepted request.
rsp_rdata  out  DATA_W  read data; 0 for writes and for errors.
rsp_err  out  1  request address was out of range; qualified by rsp_valid.
init_done  out  1  clear sequence finished.
dbg_word0  out  DATA_W  combinational view of array word 0.

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, init_done=0. The FSM enters INIT and the clear counter is 0.
- FSM INIT: while INIT_CLEAR=1, write word[cnt]=0 on each edge and increment cnt. After word DEPTH-1 is written, go to RUN; the clear takes DEPTH cycles. With INIT_CLEAR=0, go to RUN on the first edge after reset release.
- FSM RUN: init_done=1 and req_ready=1 every cycle. There is no response backpressure. Throughput is one request per cycle.
- Accept: a request is accepted on a rising edge where req_valid && req_ready. req_valid during INIT is ignored and produces no response.
- Addressing: off = req_addr - BASE_ADDR, computed as ADDR_W-bit unsigned with wrap. Addresses below the base wrap to large values and fail the range check.
- Range check: err = (off >= DEPTH*DATA_W/8).
- Word index: idx = off[log2(DEPTH)+log2(DATA_W/8)-1 : log2(DATA_W/8)]. The low byte-offset bits are ignored; alignment is the caller's job.
- Write: on the accept edge, each lane i with req_sel[i]=1 stores req_wdata lane i. If err=1, or req_sel is all zero, the array is unchanged. The response is still generated.
- Read: the array word is sampled on the accept edge. A read accepted one cycle after a write to the same word returns the new data, because the write committed on the earlier edge.
- Response pipeline: {valid, err, data} travel through RD_LAT register stages.
  - rsp_valid rises exactly RD_LAT cycles after the accept edge.
  - Back-to-back requests give back-to-back responses in order.
  - Error responses and write responses carry rdata=0.
- Reset mid-operation: all in-flight responses are dropped, with no rsp_valid afterwards. The FSM returns to INIT. Array contents are undefined until the re-clear completes, or permanently when INIT_CLEAR=0.
- dbg_word0 is a combinational read of word 0; it reflects a write on the edge that commits it.

Decomposition:
- Shared package/defines:
  - FSM state encoding (INIT, RUN).
  - Default BASE_ADDR and DEPTH constants.
  - Enable/disable constants consistent with the existing defines.
- One sub-module, dram_rsp_pipe: a parametrised RD_LAT-stage valid/err/data shift register with asynchronous active-low clear.

Test Plan:
- Reset, then INIT_CLEAR=1 with DEPTH=16 -> req_ready=0 for 16 cycles, then init_done=1. A read of 0x1001_0000 returns 0 with rsp_valid exactly RD_LAT=2 cycles after accept.
- Write 0xDEADBEEF at 0x1001_0004 with sel=4'b1111, then in the next cycle read 0x1001_0004 -> rsp_rdata=0xDEADBEEF. The write response has rdata=0 and err=0.
- Write 0x000000AA with sel=4'b0001, then 0x0000BB00 with sel=4'b0010, to 0x1001_0008, then read it -> 0x0000BBAA. A read of 0x1001_000B also returns 0x0000BBAA.
- Read 0x1000_FFFC and read 0x1001_0000+DEPTH*4 -> both responses have rsp_err=1, rdata=0. A write to the out-of-range address leaves all words unchanged.
- Four back-to-back reads of words 0..3 holding 1,2,3,4 -> four consecutive rsp_valid cycles with data 1,2,3,4 in order. Repeat with RD_LAT=1 and RD_LAT=4.
- Assert rst_n low with two reads in flight -> no rsp_valid after reset. The FSM re-enters INIT, and dbg_word0 reads 0 after the clear.
